// File: rtl/sfifo_pkg.sv
// sfifo_pkg: constants shared by the synchronous up-sizing FIFO.
//   BYTE_SIZE    - width of one byte lane of the write port.
//   RATIO_MIN/MAX and ratio_legal() - the read/write width ratios the FIFO
//   supports (1, 2 or 4); the top refuses to elaborate with anything else.
package sfifo_pkg;

  localparam int BYTE_SIZE = 8;
  localparam int RATIO_MIN = 1;
  localparam int RATIO_MAX = 4;

  function automatic bit ratio_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: simple dual-port storage for the up-sizing FIFO.
// Each row holds RATIO write words (one read word); lane 0 is the LSBs.
// Ports:
//   clk, rst      - clock; rst only clears the read data register
//   wr_en         - write one write word into lane wr_lane of row wr_row
//   wr_row        - row address (write word address / RATIO)
//   wr_lane       - lane inside the row (write word address % RATIO)
//   wr_data       - write word
//   wr_be         - byte mask; masked-off bytes are stored as zero
//   rd_en         - synchronous read of row rd_row into rd_data
//   rd_row        - row address for the read
//   rd_data       - registered read word, held between reads
module sfifo_ram
  import sfifo_pkg::*;
#(
  parameter int ROW_WIDTH     = 7,
  parameter int WR_DATA_WIDTH = 32,
  parameter int RATIO         = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ROW_WIDTH-1:0]             wr_row,
  input  logic [1:0]                       wr_lane,
  input  logic [WR_DATA_WIDTH-1:0]         wr_data,
  input  logic [WR_DATA_WIDTH/8-1:0]       wr_be,
  input  logic                             rd_en,
  input  logic [ROW_WIDTH-1:0]             rd_row,
  output logic [RATIO*WR_DATA_WIDTH-1:0]   rd_data
);

  localparam int ROWS = 2 ** ROW_WIDTH;
  localparam int NB   = WR_DATA_WIDTH / BYTE_SIZE;
  localparam int RW   = RATIO * WR_DATA_WIDTH;

  logic [RW-1:0] mem [ROWS];

  // Masked bytes are written as zero rather than left untouched, so a read
  // never exposes whatever an earlier pass through the FIFO left there.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < RATIO; l++) begin
        if (wr_lane == 2'(l)) begin
          for (int b = 0; b < NB; b++) begin
            mem[wr_row][l*WR_DATA_WIDTH + b*BYTE_SIZE +: BYTE_SIZE] <=
              wr_be[b] ? wr_data[b*BYTE_SIZE +: BYTE_SIZE] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_row];
    end
  end

endmodule

// File: rtl/sfifo_upsize.sv
// sfifo_upsize: single-clock FIFO that accepts WR_DATA_WIDTH words and
// returns RATIO*WR_DATA_WIDTH words, oldest write word in the LSB lane.
// Optional macro: SFIFO_OUT_REG_EN adds an output register (read latency 2).
// Handshake: a write is taken on a clk edge iff wr_en && !wr_full; a read is
// taken iff rd_en && !rd_empty. Flags come from registered state only, so a
// write while full is refused even if a read happens in the same cycle.
// A refused request produces a one-cycle wr_overflow / rd_underflow pulse.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   wr_data, wr_en, wr_byte_en - write word, request, byte enables
//   wr_full, almost_full     - level == depth, level >= ALMOST_FULL_NUM
//   wr_water_level           - stored write words
//   wr_overflow              - refused write pulse
//   rd_data, rd_en           - read word (1 or 2 clk after the read), request
//   rd_empty, almost_empty   - no complete read word, rd level <= ALMOST_EMPTY_NUM
//   rd_water_level           - complete read words stored
//   rd_underflow             - refused read pulse
module sfifo_upsize
  import sfifo_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = 8,
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RATIO            = 2,
  parameter int ALMOST_FULL_NUM  = 252,
  parameter int ALMOST_EMPTY_NUM = 4,
  localparam int RD_DATA_WIDTH   = RATIO * WR_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WR_DATA_WIDTH-1:0]    wr_data,
  input  logic                        wr_en,
  input  logic [WR_DATA_WIDTH/8-1:0]  wr_byte_en,
  output logic                        wr_full,
  output logic                        almost_full,
  output logic [WR_DEPTH_WIDTH:0]     wr_water_level,
  output logic                        wr_overflow,
  output logic [RD_DATA_WIDTH-1:0]    rd_data,
  input  logic                        rd_en,
  output logic                        rd_empty,
  output logic                        almost_empty,
  output logic [WR_DEPTH_WIDTH:0]     rd_water_level,
  output logic                        rd_underflow
);

  localparam int AW    = WR_DEPTH_WIDTH;
  localparam int LW    = AW + 1;
  localparam int RL    = $clog2(RATIO);
  localparam int DEPTH = 2 ** AW;

  if (!ratio_legal(RATIO) || (WR_DATA_WIDTH % BYTE_SIZE) != 0) begin : g_bad_cfg
    $error("sfifo_upsize: RATIO must be 1, 2 or 4 and WR_DATA_WIDTH a multiple of 8");
  end

  logic [LW-1:0] wr_ptr, rd_ptr, level;
  logic          wr_acc, rd_acc;
  logic [1:0]    wr_lane;
  logic [RD_DATA_WIDTH-1:0] ram_rd_data;
  logic          unused_ptr;

  // Only the row/lane bits of the pointers address storage; the wrap bit
  // and the always-zero low bits of rd_ptr are kept for the pointer width.
  assign unused_ptr = &{1'b0, wr_ptr, rd_ptr};

  assign wr_water_level = level;
  assign rd_water_level = level >> RL;
  assign wr_full        = (level == LW'(DEPTH));
  assign rd_empty       = (rd_water_level == '0);
  assign almost_full    = (int'(level) >= ALMOST_FULL_NUM);
  assign almost_empty   = (int'(rd_water_level) <= ALMOST_EMPTY_NUM);

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + LW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + LW'(RATIO);
      level        <= level + LW'(wr_acc) - (rd_acc ? LW'(RATIO) : LW'(0));
      wr_overflow  <= wr_en && wr_full;
      rd_underflow <= rd_en && rd_empty;
    end
  end

  if (RL == 0) begin : g_lane1
    assign wr_lane = 2'd0;
  end else begin : g_laneN
    assign wr_lane = 2'(wr_ptr[RL-1:0]);
  end

  sfifo_ram #(
    .ROW_WIDTH     (AW - RL),
    .WR_DATA_WIDTH (WR_DATA_WIDTH),
    .RATIO         (RATIO)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_row  (wr_ptr[AW-1:RL]),
    .wr_lane (wr_lane),
    .wr_data (wr_data),
    .wr_be   (wr_byte_en),
    .rd_en   (rd_acc),
    .rd_row  (rd_ptr[AW-1:RL]),
    .rd_data (ram_rd_data)
  );

`ifdef SFIFO_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= ram_rd_data;
    end
  end
`else
  assign rd_data = ram_rd_data;
`endif

endmodule

// File: doc/sfifo_upsize.md
SFIFO_UPSIZE -- requirements
Module: sfifo_upsize

Interface
REQ-001 The block SHALL expose parameter WR_DEPTH_WIDTH, default 8, meaning log2 of storage depth in write words.
REQ-002 The block SHALL expose parameter WR_DATA_WIDTH, default 32, meaning write word width, a multiple of 8.
REQ-003 The block SHALL expose parameter RATIO, default 2, legal values 1/2/4, meaning read width = RATIO*WR_DATA_WIDTH (RD_DATA_WIDTH, derived).
REQ-004 The block SHALL expose parameter ALMOST_FULL_NUM, default 252, meaning write-word threshold for almost_full.
REQ-005 The block SHALL expose parameter ALMOST_EMPTY_NUM, default 4, meaning read-word threshold for almost_empty.
REQ-006 The block SHALL have ports: clk in 1 clock; rst in 1 reset; wr_data in WR_DATA_WIDTH; wr_en in 1; wr_byte_en in WR_DATA_WIDTH/8; wr_full out 1; almost_full out 1; wr_water_level out WR_DEPTH_WIDTH+1; wr_overflow out 1; rd_data out RD_DATA_WIDTH; rd_en in 1; rd_empty out 1; almost_empty out 1; rd_water_level out WR_DEPTH_WIDTH+1; rd_underflow out 1.
REQ-007 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.

Function
REQ-008 Write SHALL be accepted iff wr_en=1 and wr_full=0; read SHALL be accepted iff rd_en=1 and rd_empty=0.
REQ-009 wr_water_level SHALL count stored write words; next value = current + write_accepted - RATIO*read_accepted, registered.
REQ-010 rd_water_level SHALL equal floor(wr_water_level / RATIO), i.e. complete read words only.
REQ-011 wr_full SHALL be 1 iff wr_water_level = 2**WR_DEPTH_WIDTH; rd_empty SHALL be 1 iff rd_water_level = 0.
REQ-012 almost_full SHALL be 1 iff wr_water_level >= ALMOST_FULL_NUM; almost_empty SHALL be 1 iff rd_water_level <= ALMOST_EMPTY_NUM.
REQ-013 A read SHALL return RATIO consecutive write words, oldest in least-significant lane.
REQ-014 Bytes with wr_byte_en bit = 0 SHALL be stored as 8'h00; enabled bytes stored as written.
REQ-015 Read data SHALL appear on rd_data one clk after the accepted read and SHALL hold until the next accepted read.
REQ-016 Simultaneous accepted read and write SHALL both take effect in the same cycle; flags are evaluated from registered state, so a write while full is rejected even with a concurrent read.
REQ-017 wr_overflow SHALL pulse 1 for one cycle after wr_en=1 with wr_full=1; rd_underflow SHALL pulse 1 for one cycle after rd_en=1 with rd_empty=1; rejected accesses SHALL not change pointers or levels.
REQ-018 Write and read pointers SHALL be WR_DEPTH_WIDTH+1 bits and wrap modulo 2**(WR_DEPTH_WIDTH+1); read pointer advances by RATIO.

Reset
REQ-019 On rst=1 at a clk edge, pointers and levels SHALL clear to 0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, wr_overflow=0, rd_underflow=0, rd_data=0.
REQ-020 Reset mid-operation SHALL discard all stored data; wr_en/rd_en during rst SHALL be ignored.

Configuration
REQ-021 Macro SFIFO_OUT_REG_EN, when defined, SHALL add an output register so rd_data appears two clk after the accepted read (reset value 0); when undefined, latency SHALL be one clk per REQ-015.

Structure
REQ-022 Shared package sfifo_pkg SHALL hold BYTE_SIZE (8) and legal-RATIO check constants.
REQ-023 Storage SHALL be a sub-module sfifo_ram: simple dual-port, write port WR_DATA_WIDTH with byte mask, read port RD_DATA_WIDTH, synchronous read.

Verification
REQ-024 Reset, write 256 words 0xFFFFFFFF counting down, all byte enables 1 -> after last write wr_full=1, wr_water_level=256, rd_water_level=128, almost_full=1.
REQ-025 Then read 128 words -> first rd_data 0xFFFFFFFE_FFFFFFFF, last 0xFFFFFF00_FFFFFF01, rd_empty=1 after last, no rd_underflow.
REQ-026 Write 3 words -> rd_water_level=1; one read -> rd_empty=1 while wr_water_level=1; further rd_en -> rd_underflow pulse, level unchanged.
REQ-027 Write 0xAABBCCDD with wr_byte_en=4'b0101 then 0x11223344 with 4'b1111 -> read returns 0x11223344_00BB00DD.
REQ-028 Full FIFO, simultaneous wr_en and rd_en -> read accepted, write rejected, wr_overflow=1, wr_water_level=254.
REQ-029 Assert rst after 10 writes, then write 2 and read 1 -> rd_data equals the two post-reset words; no pre-reset data returned.
